pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the fetch stage of the pipelined core. Holds the fetch address, selects the next PC from sequential increment, jump, call, return, branch redirect and exception vector by fixed priority, and keeps a small circular return-address stack (RAS) for call/return. It replaces the bare PC register. Reset is explicit and asynchronous, and a one-cycle boot state marks the first valid fetch.

## Interface
- WIDTH, 32, PC and target width (≥ 8)
- RESET_VECTOR, 32'h0000_0000, PC value while in reset and during boot
- EXC_VECTOR, 32'h0000_0180, exception handler address
- INC, 4, sequential increment
- RAS_DEPTH, 4, return-stack entries (power of 2, ≥ 2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- stall  in  1  hold PC; blocks jump/call/ret
- exception  in  1  redirect to EXC_VECTOR
- branch_taken  in  1  redirect to branch_target (resolved in EX)
- branch_target  in  WIDTH  branch destination
- jump  in  1  redirect to jump_target (decoded in ID)
- call  in  1  push link_addr, redirect to jump_target
- ret  in  1  pop RAS, redirect to popped address
- jump_target  in  WIDTH  jump/call destination
- link_addr  in  WIDTH  return address pushed on call
- ret_fallback  in  WIDTH  ret destination when RAS is empty
- pc  out  WIDTH  current fetch address (registered)
- pc_next_seq  out  WIDTH  pc + INC (combinational)
- valid  out  1  pc is a real fetch address
- flush  out  1  redirect accepted this cycle (combinational)
- ras_empty  out  1  RAS count == 0
- ras_full  out  1  RAS count == RAS_DEPTH

## Operation
- FSM states:
  - RESET: entered asynchronously while reset = 1.
  - BOOT: entered on the first clk edge after reset deasserts. Lasts exactly one cycle.
  - RUN: steady state.
- Reset values: pc = RESET_VECTOR, valid = 0, RAS count = 0, RAS pointer = 0, flush = 0.
- BOOT: pc holds RESET_VECTOR and all inputs are ignored. On the next edge the FSM enters RUN and valid goes to 1.
- Next-PC priority in RUN, highest first:
  1. exception → EXC_VECTOR
  2. branch_taken → branch_target
  3. stall → hold pc
  4. ret → RAS top, or ret_fallback if the RAS is empty
  5. call → jump_target
  6. jump → jump_target
  7. otherwise → pc + INC
- exception and branch_taken override stall. jump, call and ret have no effect while stall = 1.
- flush = 1 in RUN when exception, branch_taken, or (~stall & (jump | call | ret)) is asserted. flush = 0 in RESET and BOOT.
- RAS updates only when the ret/call request wins priority. There is no stack change when exception, branch_taken or stall is active.
- call on a non-full RAS: push link_addr, count +1.
- call on a full RAS: overwrite the oldest entry (circular), count stays at RAS_DEPTH.
- ret on a non-empty RAS: pop, count −1.
- ret on an empty RAS: use ret_fallback, RAS unchanged.
- call and ret asserted together: redirect to the current top (or ret_fallback if empty), then replace the top with link_addr.
  - Count is unchanged if it was non-zero.
  - If the RAS was empty, count becomes 1.
- Arithmetic: pc + INC wraps modulo 2^WIDTH. Bits [1:0] of every loaded target (branch, jump, RAS, fallback, vectors) are forced to 0.

## Timing
- pc updates on the rising clk edge following a request. There is one cycle of latency from a request to the new pc.
- flush is combinational, in the same cycle as the request.
- reset assertion takes effect immediately, mid-cycle, and clears the RAS. Deassertion is synchronous to the next edge, which enters BOOT.
- RAS read of the top entry is combinational. The push/pop pointer update is registered on the same edge as the pc update.
- All outputs are glitch-free registered values except pc_next_seq, flush, ras_empty and ras_full (decode of registered state plus inputs).

## Test plan
- Reset then idle: assert reset for 3 cycles, then release. Required response:
  - pc = 0 and valid = 0 through the BOOT cycle.
  - Then valid = 1 and pc steps 0x0 → 0x4 → 0x8 → 0xC.
- Stall vs. branch: at pc = 0x10, hold stall = 1 for 2 cycles. Required response:
  - pc stays at 0x10.
  - Adding branch_taken = 1 with branch_target = 0x103 gives pc = 0x100 next cycle and flush = 1.
- Priority: exception, branch_taken and jump all asserted in one cycle. Required response: pc = 0x180 next cycle and the RAS is unchanged.
- RAS overflow: 5 calls with link_addr = 0x20, 0x24, 0x28, 0x2C, 0x30, then 5 rets with ret_fallback = 0x400. Required response:
  - ras_full = 1 after the 4th call.
  - ret targets are 0x30, 0x2C, 0x28, 0x24, then 0x400.
  - ras_empty = 1 after the 4th ret.
- Simultaneous call+ret with top = 0x44 and link_addr = 0x88. Required response: pc = 0x44, count unchanged, and a following ret returns 0x88.
- Wrap and mid-run reset: with WIDTH = 8 at pc = 0xFC, the sequential step gives pc = 0x00. Asserting reset asynchronously mid-cycle forces pc = RESET_VECTOR and valid = 0 immediately, and clears the RAS.

Source files
------------

// File: rtl/pc_unit_if.sv
// Fetch-stage PC unit bus: control requests and targets in, fetch address and RAS status out.
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             exception;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] link_addr;
  logic [WIDTH-1:0] ret_fallback;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next_seq;
  logic             valid;
  logic             flush;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    output stall, exception, branch_taken, branch_target, jump, call, ret,
           jump_target, link_addr, ret_fallback,
    input  pc, pc_next_seq, valid, flush, ras_empty, ras_full
  );

  modport slave (
    input  stall, exception, branch_taken, branch_target, jump, call, ret,
           jump_target, link_addr, ret_fallback,
    output pc, pc_next_seq, valid, flush, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: fixed-priority next-PC select with a circular return-address stack.
//
// state    | meaning
// ST_RESET | reset asserted or just released; pc = reset vector, valid = 0
// ST_BOOT  | single cycle after release; inputs ignored, pc held
// ST_RUN   | normal fetch; next-PC priority and RAS updates active
module pc_unit #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int          INC          = 4,
  parameter int          RAS_DEPTH    = 4
) (
  input logic      clk,
  input logic      reset,
  pc_unit_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [WIDTH-1:0] ALIGN    = ~WIDTH'(3);
  localparam logic [WIDTH-1:0] RST_PC   = WIDTH'(RESET_VECTOR) & ALIGN;
  localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VECTOR) & ALIGN;
  localparam logic [CW-1:0]    FULL_CNT = CW'(RAS_DEPTH);

  typedef enum logic [1:0] {ST_RESET, ST_BOOT, ST_RUN} state_t;
  typedef enum logic [1:0] {RAS_NONE, RAS_PUSH, RAS_POP, RAS_SWAP} ras_op_t;

  state_t           state_q, state_d;
  ras_op_t          ras_op;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q;
  logic             flush_c;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    top_idx;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic             empty_c;
  logic             full_c;

  // ptr_q is the next free slot; once full it also points at the oldest entry
  assign top_idx = ptr_q - PW'(1);
  assign empty_c = (cnt_q == '0);
  assign full_c  = (cnt_q == FULL_CNT);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_c = 1'b0;
    ras_op  = RAS_NONE;
    case (state_q)
      ST_RESET: state_d = ST_BOOT;
      ST_BOOT:  state_d = ST_RUN;
      default: begin
        if (bus.exception) begin
          pc_d    = EXC_PC;
          flush_c = 1'b1;
        end else if (bus.branch_taken) begin
          pc_d    = bus.branch_target & ALIGN;
          flush_c = 1'b1;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.ret) begin
          flush_c = 1'b1;
          pc_d    = (empty_c ? bus.ret_fallback : ras_mem[top_idx]) & ALIGN;
          if (bus.call)      ras_op = RAS_SWAP;
          else if (!empty_c) ras_op = RAS_POP;
        end else if (bus.call) begin
          flush_c = 1'b1;
          pc_d    = bus.jump_target & ALIGN;
          ras_op  = RAS_PUSH;
        end else if (bus.jump) begin
          flush_c = 1'b1;
          pc_d    = bus.jump_target & ALIGN;
        end else begin
          pc_d = pc_q + WIDTH'(INC);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
      pc_q    <= RST_PC;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= (state_d == ST_RUN);
      case (ras_op)
        RAS_PUSH: begin
          ras_mem[ptr_q] <= bus.link_addr;
          ptr_q          <= ptr_q + PW'(1);
          if (!full_c) cnt_q <= cnt_q + CW'(1);
        end
        RAS_POP: begin
          ptr_q <= top_idx;
          cnt_q <= cnt_q - CW'(1);
        end
        RAS_SWAP: begin
          ras_mem[top_idx] <= bus.link_addr;
          if (empty_c) cnt_q <= CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_next_seq = pc_q + WIDTH'(INC);
  assign bus.valid       = valid_q;
  assign bus.flush       = flush_c;
  assign bus.ras_empty   = empty_c;
  assign bus.ras_full    = full_c;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_pc_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;
  localparam logic [31:0] EXC   = 32'h0000_0180;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst8 = 1'b1;
  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(32)) a_if ();
  pc_unit_if #(.WIDTH(8))  b_if ();

  pc_unit #(.WIDTH(32)) dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));
  pc_unit #(.WIDTH(8), .EXC_VECTOR(32'h80)) dut_b (.clk(clk), .reset(rst8), .bus(b_if.slave));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: phase 0 = reset, 1 = boot, 2 = run; RAS as a bounded queue, newest at the back
  int          m_phase;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_ras[$];

  function automatic void model_reset();
    m_phase = 0;
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_ras.delete();
  endfunction

  function automatic logic model_flush();
    if (m_phase != 2) return 1'b0;
    return a_if.exception | a_if.branch_taken |
           (!a_if.stall & (a_if.jump | a_if.call | a_if.ret));
  endfunction

  function automatic void model_update();
    logic [31:0] tgt;
    if (m_phase == 0) m_phase = 1;
    else if (m_phase == 1) begin
      m_phase = 2;
      m_valid = 1'b1;
    end else if (a_if.exception) m_pc = EXC & ALIGN;
    else if (a_if.branch_taken) m_pc = a_if.branch_target & ALIGN;
    else if (a_if.stall) m_pc = m_pc;
    else if (a_if.ret) begin
      tgt = (m_ras.size() == 0) ? a_if.ret_fallback : m_ras[m_ras.size()-1];
      if (a_if.call) begin
        if (m_ras.size() == 0) m_ras.push_back(a_if.link_addr);
        else m_ras[m_ras.size()-1] = a_if.link_addr;
      end else if (m_ras.size() > 0) void'(m_ras.pop_back());
      m_pc = tgt & ALIGN;
    end else if (a_if.call) begin
      if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
      m_ras.push_back(a_if.link_addr);
      m_pc = a_if.jump_target & ALIGN;
    end else if (a_if.jump) m_pc = a_if.jump_target & ALIGN;
    else m_pc = m_pc + 32'd4;
  endfunction

  task automatic step();
    @(negedge clk);
    chk("pc", a_if.pc, m_pc);
    chk("valid", 32'(a_if.valid), 32'(m_valid));
    chk("flush", 32'(a_if.flush), 32'(model_flush()));
    chk("ras_empty", 32'(a_if.ras_empty), 32'(m_ras.size() == 0));
    chk("ras_full", 32'(a_if.ras_full), 32'(m_ras.size() == DEPTH));
    chk("pc_next_seq", a_if.pc_next_seq, m_pc + 32'd4);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    a_if.stall = 0; a_if.exception = 0; a_if.branch_taken = 0; a_if.jump = 0;
    a_if.call = 0; a_if.ret = 0;
    a_if.branch_target = 0; a_if.jump_target = 0; a_if.link_addr = 0; a_if.ret_fallback = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_pc", a_if.pc, 32'h0);
    chk("rst_valid", 32'(a_if.valid), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] ret_exp [5];
    ret_exp[0] = 32'h30; ret_exp[1] = 32'h2C; ret_exp[2] = 32'h28;
    ret_exp[3] = 32'h24; ret_exp[4] = 32'h400;
    idle_inputs();
    b_if.stall = 0; b_if.exception = 0; b_if.branch_taken = 0; b_if.jump = 0;
    b_if.call = 0; b_if.ret = 0; b_if.branch_target = 0; b_if.jump_target = 0;
    b_if.link_addr = 0; b_if.ret_fallback = 0;
    model_reset();

    // reset for 3 cycles, then idle through boot
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", a_if.pc, 32'h0);
    chk("rst_valid", 32'(a_if.valid), 32'h0);
    reset = 1'b0;
    step();
    step();
    chk("boot_done_valid", 32'(a_if.valid), 32'h1);
    chk("boot_done_pc", a_if.pc, 32'h0);
    for (int i = 0; i < 8 && m_pc != 32'h10; i++) step();
    chk("reach_0x10", a_if.pc, 32'h10);

    // stall holds, branch overrides stall
    a_if.stall = 1;
    step();
    step();
    chk("stall_hold", a_if.pc, 32'h10);
    a_if.branch_taken = 1;
    a_if.branch_target = 32'h103;
    #1;
    chk("br_flush", 32'(a_if.flush), 32'h1);
    step();
    chk("br_pc", a_if.pc, 32'h100);
    idle_inputs();

    // overflow: 5 calls, then 5 rets
    do_reset();
    step();
    step();
    a_if.jump_target = 32'h200;
    a_if.call = 1;
    for (int i = 0; i < 5; i++) begin
      a_if.link_addr = 32'h20 + 32'(4 * i);
      step();
      if (i == 3) chk("ras_full_4th", 32'(a_if.ras_full), 32'h1);
    end
    a_if.call = 0;
    a_if.ret = 1;
    a_if.ret_fallback = 32'h400;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ret_target", a_if.pc, ret_exp[i]);
      if (i == 3) chk("ras_empty_4th", 32'(a_if.ras_empty), 32'h1);
    end
    idle_inputs();

    // priority: exception beats branch and jump, RAS untouched
    a_if.call = 1; a_if.link_addr = 32'h50; a_if.jump_target = 32'h240;
    step();
    idle_inputs();
    a_if.exception = 1; a_if.branch_taken = 1; a_if.branch_target = 32'h500;
    a_if.jump = 1; a_if.jump_target = 32'h600;
    step();
    chk("prio_pc", a_if.pc, 32'h180);
    chk("prio_ras", 32'(a_if.ras_empty), 32'h0);
    idle_inputs();
    a_if.ret = 1;
    step();
    chk("prio_ret", a_if.pc, 32'h50);
    idle_inputs();

    // simultaneous call + ret
    a_if.call = 1; a_if.link_addr = 32'h44; a_if.jump_target = 32'h300;
    step();
    a_if.ret = 1; a_if.link_addr = 32'h88;
    step();
    chk("swap_pc", a_if.pc, 32'h44);
    a_if.call = 0;
    step();
    chk("swap_ret", a_if.pc, 32'h88);
    chk("swap_empty", 32'(a_if.ras_empty), 32'h1);
    idle_inputs();

    // random traffic
    for (int i = 0; i < 500; i++) begin
      a_if.exception     = ($urandom_range(31) == 0);
      a_if.branch_taken  = ($urandom_range(7) == 0);
      a_if.stall         = ($urandom_range(4) == 0);
      a_if.ret           = ($urandom_range(4) == 0);
      a_if.call          = ($urandom_range(3) == 0);
      a_if.jump          = ($urandom_range(7) == 0);
      a_if.branch_target = $urandom;
      a_if.jump_target   = $urandom;
      a_if.link_addr     = $urandom;
      a_if.ret_fallback  = $urandom;
      step();
    end
    idle_inputs();

    // mid-cycle asynchronous reset clears pc, valid and RAS
    a_if.call = 1; a_if.link_addr = 32'h70; a_if.jump_target = 32'h700;
    step();
    idle_inputs();
    chk("pre_rst_ras", 32'(a_if.ras_empty), 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_pc", a_if.pc, 32'h0);
    chk("async_valid", 32'(a_if.valid), 32'h0);
    chk("async_ras", 32'(a_if.ras_empty), 32'h1);

    // 8-bit instance: wrap past 0xFC and async reset
    rst8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("w8_valid", 32'(b_if.valid), 32'h1);
    b_if.jump = 1; b_if.jump_target = 8'hFC;
    @(posedge clk);
    #1;
    b_if.jump = 0;
    chk("w8_pc_fc", 32'(b_if.pc), 32'hFC);
    chk("w8_next_seq", 32'(b_if.pc_next_seq), 32'h00);
    @(posedge clk);
    #1;
    chk("w8_wrap", 32'(b_if.pc), 32'h00);
    b_if.call = 1; b_if.link_addr = 8'h10; b_if.jump_target = 8'h40;
    @(posedge clk);
    #1;
    b_if.call = 0;
    chk("w8_call", 32'(b_if.pc), 32'h40);
    chk("w8_ras", 32'(b_if.ras_empty), 32'h0);
    #2;
    rst8 = 1'b1;
    #1;
    chk("w8_async_pc", 32'(b_if.pc), 32'h00);
    chk("w8_async_valid", 32'(b_if.valid), 32'h0);
    chk("w8_async_ras", 32'(b_if.ras_empty), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
